imem_fetch_controller: RTL and testbench

- Sequences the byte-addressed, combinational-read instruction memory: owns the PC and drives the fetch address.
- Captures each 32-bit instruction with its PC into a 2-entry fetch queue and presents it to decode over a valid/ready handshake.
- Applies stall (backpressure), branch/jump redirect with flush, and halt at the end of the populated memory image.
- Sits between the instruction memory and the IF/ID pipeline register.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_queue.sv | 45 ++++
 rtl/imem_fetch_controller.sv | 105 ++++++++++
 tb/tb_imem_fetch_controller.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller and its fetch queue.
package fetch_pkg;

  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned ADDR_W    = 64;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry fetch FIFO holding {pc, instr} pairs; flush empties it in one cycle.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t push_data_i,
  output logic         full_o,
  output logic         empty_o,
  output fetch_entry_t head_o
);

  fetch_entry_t entry_q [2];
  logic         rd_ptr_q, wr_ptr_q;
  logic [1:0]   count_q;

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked entirely by count_q.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i && !reset) entry_q[wr_ptr_q] <= push_data_i;
  end

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign head_o  = entry_q[rd_ptr_q];

endmodule

// File: rtl/imem_fetch_controller.sv
// PC / fetch FSM in front of a combinational instruction memory, feeding decode via a 2-entry queue.
// Optional performance counters enabled by defining FETCH_PERF_CNT_EN.
module imem_fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'd0,
  parameter int unsigned IMEM_BYTES = 12,
  parameter int unsigned QDEPTH     = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [63:0] id_pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] fetch_count,
  output logic [15:0] flush_count,
`endif
  output logic        halted
);

  localparam logic [63:0] IMEM_LIMIT = 64'(IMEM_BYTES);

  fetch_state_t state_q;
  logic [63:0]  pc_q;
  logic         q_full, q_empty;
  fetch_entry_t q_head, q_push_data;
  logic         in_range, dequeue, enqueue;

  assign in_range = (pc_q + 64'd4) <= IMEM_LIMIT;
  assign dequeue  = id_valid && id_ready && !redirect_valid;
  assign enqueue  = (state_q == FETCH) && !redirect_valid && in_range && (!q_full || dequeue);

  assign q_push_data.pc    = pc_q;
  assign q_push_data.instr = imem_instr;

  fetch_queue u_queue (
    .clk         (clk),
    .reset       (reset),
    .push_i      (enqueue),
    .pop_i       (dequeue),
    .flush_i     (redirect_valid),
    .push_data_i (q_push_data),
    .full_o      (q_full),
    .empty_o     (q_empty),
    .head_o      (q_head)
  );

  // Redirect outranks both the end-of-image halt and normal sequential fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
    end else if (redirect_valid) begin
      state_q <= FETCH;
      pc_q    <= redirect_pc & ~64'd3;
    end else begin
      case (state_q)
        FETCH: begin
          if (enqueue)        pc_q    <= pc_q + 64'd4;
          else if (!in_range) state_q <= HALT;
        end
        default: state_q <= HALT;
      endcase
    end
  end

  assign imem_addr = pc_q;
  assign halted    = (state_q == HALT);
  assign id_valid  = !q_empty;
  assign id_instr  = id_valid ? q_head.instr : NOP_INSTR;
  assign id_pc     = id_valid ? q_head.pc    : 64'd0;

`ifdef FETCH_PERF_CNT_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

  logic [31:0] fetch_count_q;
  logic [15:0] flush_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_q <= 32'd0;
      flush_count_q <= 16'd0;
    end else begin
      if (enqueue)        fetch_count_q <= sat_inc32(fetch_count_q);
      if (redirect_valid) flush_count_q <= sat_inc16(flush_count_q);
    end
  end

  assign fetch_count = fetch_count_q;
  assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_imem_fetch_controller.sv
// Directed self-checking bench for imem_fetch_controller with a 3-word combinational memory.
module tb_imem_fetch_controller;

  logic        clk;
  logic        reset;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [63:0] id_pc;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [15:0] flush_count;
`endif

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [4];

  imem_fetch_controller #(
    .RESET_PC   (64'd0),
    .IMEM_BYTES (12),
    .QDEPTH     (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
`ifdef FETCH_PERF_CNT_EN
    .fetch_count    (fetch_count),
    .flush_count    (flush_count),
`endif
    .halted         (halted)
  );

  assign imem_instr = (imem_addr < 64'd12) ? mem[imem_addr[3:2]] : 32'h00000000;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    mem[0] = 32'h00500193;
    mem[1] = 32'h00300233;
    mem[2] = 32'h000202b3;
    mem[3] = 32'h00000000;
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 64'd0;
    id_ready = 1'b1;
    tick();
    tick();
    chk("rst_valid", 64'(id_valid), 64'd0);
    chk("rst_instr", 64'(id_instr), 64'h13);
    chk("rst_pc", id_pc, 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_addr", imem_addr, 64'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_fetch_cnt", 64'(fetch_count), 64'd0);
    chk("rst_flush_cnt", 64'(flush_count), 64'd0);
`endif
    reset = 1'b0;

    // Streaming with decode always ready
    tick();
    chk("s1_valid0", 64'(id_valid), 64'd1);
    chk("s1_pc0", id_pc, 64'd0);
    chk("s1_instr0", 64'(id_instr), 64'h00500193);
    tick();
    chk("s1_pc4", id_pc, 64'd4);
    chk("s1_instr4", 64'(id_instr), 64'h00300233);
    tick();
    chk("s1_pc8", id_pc, 64'd8);
    chk("s1_instr8", 64'(id_instr), 64'h000202b3);
    chk("s1_not_halted", 64'(halted), 64'd0);
    tick();
    chk("s1_halted", 64'(halted), 64'd1);
    chk("s1_drained", 64'(id_valid), 64'd0);
    chk("s1_nop", 64'(id_instr), 64'h13);
    chk("s1_pc_zero", id_pc, 64'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetch3", 64'(fetch_count), 64'd3);
    chk("perf_flush0", 64'(flush_count), 64'd0);
`endif

    // Redirect out of HALT, then a misaligned target
    redirect_valid = 1'b1;
    redirect_pc = 64'd0;
    tick();
    chk("h_unhalt", 64'(halted), 64'd0);
    chk("h_addr0", imem_addr, 64'd0);
    chk("h_valid0", 64'(id_valid), 64'd0);
    redirect_valid = 1'b0;
    tick();
    chk("h_refetch_valid", 64'(id_valid), 64'd1);
    chk("h_refetch_pc", id_pc, 64'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetch4", 64'(fetch_count), 64'd4);
    chk("perf_flush1", 64'(flush_count), 64'd1);
`endif
    redirect_valid = 1'b1;
    redirect_pc = 64'd6;
    tick();
    chk("mis_addr", imem_addr, 64'd4);
    chk("mis_flushed", 64'(id_valid), 64'd0);
    redirect_valid = 1'b0;
    tick();
    chk("mis_pc", id_pc, 64'd4);
    chk("mis_instr", 64'(id_instr), 64'h00300233);

    // Out-of-range redirect halts on the following cycle
    redirect_valid = 1'b1;
    redirect_pc = 64'd12;
    tick();
    chk("oor_addr", imem_addr, 64'd12);
    chk("oor_not_halted", 64'(halted), 64'd0);
    redirect_valid = 1'b0;
    tick();
    chk("oor_halted", 64'(halted), 64'd1);
    chk("oor_empty", 64'(id_valid), 64'd0);

    // Backpressure: queue fills, PC holds, then drains in order
    id_ready = 1'b0;
    do_reset();
    repeat (5) tick();
    chk("bp_addr_hold", imem_addr, 64'd8);
    chk("bp_head_pc", id_pc, 64'd0);
    chk("bp_valid", 64'(id_valid), 64'd1);
    id_ready = 1'b1;
    tick();
    chk("bp_rel_pc4", id_pc, 64'd4);
    chk("bp_rel_addr", imem_addr, 64'd12);
    tick();
    chk("bp_rel_pc8", id_pc, 64'd8);
    chk("bp_rel_halted", 64'(halted), 64'd1);
    tick();
    chk("bp_rel_empty", 64'(id_valid), 64'd0);

    // Reset with two entries queued
    id_ready = 1'b0;
    do_reset();
    tick();
    tick();
    chk("mr_full_pc", id_pc, 64'd0);
    reset = 1'b1;
    tick();
    chk("mr_valid", 64'(id_valid), 64'd0);
    chk("mr_addr", imem_addr, 64'd0);
    chk("mr_halted", 64'(halted), 64'd0);
    reset = 1'b0;

    // Redirect while the queue holds pc 0 and 4
    tick();
    tick();
    chk("rd_pre_head", id_pc, 64'd0);
    redirect_valid = 1'b1;
    redirect_pc = 64'd4;
    tick();
    chk("rd_flush_valid", 64'(id_valid), 64'd0);
    chk("rd_addr", imem_addr, 64'd4);
    redirect_valid = 1'b0;
    tick();
    chk("rd_pc", id_pc, 64'd4);
    chk("rd_instr", 64'(id_instr), 64'h00300233);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
